// File: rtl/nic_ctrl_pkg.sv
// Shared definitions for the NIC access controller.
//   nic_state_e : sequencer states (IDLE / POLL_RX / READ_RX / POLL_TX / WRITE_TX)
//   srv_e       : which direction was served last (round-robin memory)
//   NIC_*       : NIC memory-mapped register select codes
//   stat_bit()  : bit position of the full flag inside a NIC status word
package nic_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_POLL_RX  = 3'd1,
    ST_READ_RX  = 3'd2,
    ST_POLL_TX  = 3'd3,
    ST_WRITE_TX = 3'd4
  } nic_state_e;

  typedef enum logic {
    SRV_TX = 1'b0,
    SRV_RX = 1'b1
  } srv_e;

  localparam logic [0:1] NIC_IN_DATA  = 2'b00;
  localparam logic [0:1] NIC_IN_STAT  = 2'b01;
  localparam logic [0:1] NIC_OUT_DATA = 2'b10;
  localparam logic [0:1] NIC_OUT_STAT = 2'b11;

  // Status words carry the full flag in the last bit of the packet vector.
  function automatic int unsigned stat_bit(input int unsigned pac_width);
    return pac_width - 1;
  endfunction

endpackage

// File: rtl/nic_access_ctrl.sv
// NIC access controller: owns the memory-mapped port of one NIC for a PE.
// Tx packets are buffered in a one-deep holding register and pushed to the
// NIC as "poll out-status, write out-buffer"; NIC receive traffic is pulled as
// "poll in-status, read in-buffer" into a registered rx valid/ready output.
// Tx and rx service are arbitrated round-robin.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   tx_valid/tx_data    packet from PE (bit 0 = VC bit, not inspected)
//   tx_ready            holding register empty
//   rx_valid/rx_data    received packet to PE (registered)
//   rx_ready            PE consumes rx_data
//   nic_addr/nic_en/nic_wr_en/nic_d_in   NIC register port (Moore outputs)
//   nic_d_out           NIC read data, combinational on nic_addr
//   sent_cnt/recv_cnt   wrapping packet counters
module nic_access_ctrl
  import nic_ctrl_pkg::*;
#(
  parameter int unsigned PAC_WIDTH = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [0:PAC_WIDTH-1] tx_data,
  output logic                 tx_ready,
  output logic                 rx_valid,
  output logic [0:PAC_WIDTH-1] rx_data,
  input  logic                 rx_ready,
  output logic [0:1]           nic_addr,
  output logic                 nic_en,
  output logic                 nic_wr_en,
  output logic [0:PAC_WIDTH-1] nic_d_in,
  input  logic [0:PAC_WIDTH-1] nic_d_out,
  output logic [CNT_W-1:0]     sent_cnt,
  output logic [CNT_W-1:0]     recv_cnt
);

  localparam int unsigned STAT_BIT = stat_bit(PAC_WIDTH);

  nic_state_e             state_q, state_d;
  srv_e                   last_q, last_d;
  logic                   tx_full_q, tx_full_d;
  logic [0:PAC_WIDTH-1]   tx_buf_q, tx_buf_d;
  logic                   rx_valid_q, rx_valid_d;
  logic [0:PAC_WIDTH-1]   rx_data_q, rx_data_d;
  logic [CNT_W-1:0]       sent_q, sent_d;
  logic [CNT_W-1:0]       recv_q, recv_d;

  logic rx_want;
  logic tx_want;
  logic nic_full;

  assign rx_want  = !rx_valid_q;
  assign tx_want  = tx_full_q;
  assign nic_full = nic_d_out[STAT_BIT];

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    tx_full_d  = tx_full_q;
    tx_buf_d   = tx_buf_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    sent_d     = sent_q;
    recv_d     = recv_q;
    nic_en     = 1'b0;
    nic_wr_en  = 1'b0;
    nic_addr   = NIC_IN_DATA;
    nic_d_in   = '0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (tx_valid && !tx_full_q) begin
      tx_full_d = 1'b1;
      tx_buf_d  = tx_data;
    end

    case (state_q)
      ST_IDLE: begin
        // Contention goes to the direction not served last.
        if (rx_want && (!tx_want || last_q == SRV_TX)) begin
          state_d = ST_POLL_RX;
        end else if (tx_want) begin
          state_d = ST_POLL_TX;
        end
      end
      ST_POLL_RX: begin
        nic_en   = 1'b1;
        nic_addr = NIC_IN_STAT;
        if (nic_full) begin
          state_d = ST_READ_RX;
        end else begin
          state_d = ST_IDLE;
          last_d  = SRV_RX;
        end
      end
      ST_READ_RX: begin
        // Only this block pops the in-buffer, so the positive poll still holds.
        nic_en     = 1'b1;
        nic_addr   = NIC_IN_DATA;
        rx_data_d  = nic_d_out;
        rx_valid_d = 1'b1;
        recv_d     = recv_q + CNT_W'(1);
        last_d     = SRV_RX;
        state_d    = ST_IDLE;
      end
      ST_POLL_TX: begin
        nic_en   = 1'b1;
        nic_addr = NIC_OUT_STAT;
        if (!nic_full) begin
          state_d = ST_WRITE_TX;
        end else begin
          state_d = ST_IDLE;
          last_d  = SRV_TX;
        end
      end
      ST_WRITE_TX: begin
        nic_en    = 1'b1;
        nic_wr_en = 1'b1;
        nic_addr  = NIC_OUT_DATA;
        nic_d_in  = tx_buf_q;
        tx_full_d = 1'b0;
        sent_d    = sent_q + CNT_W'(1);
        last_d    = SRV_TX;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      last_q     <= SRV_TX;
      tx_full_q  <= 1'b0;
      tx_buf_q   <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      sent_q     <= '0;
      recv_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      tx_full_q  <= tx_full_d;
      tx_buf_q   <= tx_buf_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      sent_q     <= sent_d;
      recv_q     <= recv_d;
    end
  end

  assign tx_ready = !tx_full_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign sent_cnt = sent_q;
  assign recv_cnt = recv_q;

endmodule

// File: tb/tb_nic_access_ctrl.sv
// Bench for nic_access_ctrl: a behavioural NIC (one in-slot, one out-slot)
// plus transaction scoreboards for tx and rx, with directed scenarios and a
// randomized phase. Counters are instantiated narrow so wrap is reachable.
module tb_nic_access_ctrl;

  localparam int unsigned PW = 64;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          tx_valid;
  logic [0:PW-1] tx_data;
  logic          tx_ready;
  logic          rx_valid;
  logic [0:PW-1] rx_data;
  logic          rx_ready;
  logic [0:1]    nic_addr;
  logic          nic_en;
  logic          nic_wr_en;
  logic [0:PW-1] nic_d_in;
  logic [0:PW-1] nic_d_out;
  logic [CW-1:0] sent_cnt;
  logic [CW-1:0] recv_cnt;

  always #5 clk = ~clk;

  nic_access_ctrl #(.PAC_WIDTH(PW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .nic_addr(nic_addr), .nic_en(nic_en), .nic_wr_en(nic_wr_en),
    .nic_d_in(nic_d_in), .nic_d_out(nic_d_out),
    .sent_cnt(sent_cnt), .recv_cnt(recv_cnt)
  );

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [3:0] nic_ctl();
    return {nic_en, nic_wr_en, nic_addr};
  endfunction

  // ---------------- behavioural NIC ----------------
  logic          in_full, out_full;
  logic [0:PW-1] in_pkt;
  int unsigned   in_pct, drain_pct;
  logic          pend_pop, pend_wr;

  always_comb begin
    nic_d_out = '0;
    case (nic_addr)
      2'b00:   nic_d_out = in_pkt;
      2'b01:   nic_d_out[PW-1] = in_full;
      2'b11:   nic_d_out[PW-1] = out_full;
      default: nic_d_out = '0;
    endcase
  end

  // NIC state moves 1 time unit after the edge that performed the access.
  always begin
    @(posedge clk);
    #1;
    if (pend_pop) in_full = 1'b0;
    if (pend_wr)  out_full = 1'b1;
    pend_pop = 1'b0;
    pend_wr  = 1'b0;
    if (out_full && $urandom_range(99) < drain_pct) out_full = 1'b0;
    if (!in_full && $urandom_range(99) < in_pct) begin
      in_full = 1'b1;
      in_pkt  = {$urandom, $urandom};
    end
  end

  // ---------------- scoreboard / protocol monitor ----------------
  logic          mon_en;
  logic [0:PW-1] txq[$];
  logic [0:PW-1] rxq[$];
  int unsigned   n_sent, n_recv;
  logic          hold_q;
  logic [0:PW-1] hold_data;

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("tx_ready", 64'(tx_ready), 64'(txq.size() == 0));
      check_eq("rx_valid", 64'(rx_valid), 64'(rxq.size() != 0));
      check_eq("sent_cnt", 64'(sent_cnt), 64'(CW'(n_sent)));
      check_eq("recv_cnt", 64'(recv_cnt), 64'(CW'(n_recv)));
      if (!nic_en) check_eq("idle_ctl", 64'({nic_wr_en, nic_addr}), 64'(0));
      if (!nic_wr_en) check_eq("d_in_zero", nic_d_in, 64'(0));
      else check_eq("wr_addr", 64'({nic_en, nic_addr}), 64'(3'b110));
      if (hold_q) begin
        check_eq("rx_hold_v", 64'(rx_valid), 64'(1));
        check_eq("rx_hold_d", rx_data, hold_data);
      end
      if (!reset) begin
        txq.delete();
        rxq.delete();
        n_sent = 0;
        n_recv = 0;
        hold_q = 1'b0;
      end else begin
        if (nic_en && !nic_wr_en && nic_addr == 2'b00) begin
          check_eq("pop_full", 64'(in_full), 64'(1));
          rxq.push_back(in_pkt);
          n_recv++;
          pend_pop = 1'b1;
        end
        if (nic_en && nic_wr_en && nic_addr == 2'b10) begin
          check_eq("wr_space", 64'(out_full), 64'(0));
          check_eq("tx_depth", 64'(txq.size()), 64'(1));
          if (txq.size() != 0) check_eq("tx_data", nic_d_in, txq.pop_front());
          n_sent++;
          pend_wr = 1'b1;
        end
        if (rx_valid && rx_ready && rxq.size() != 0) check_eq("rx_data", rx_data, rxq.pop_front());
        hold_q    = rx_valid && !rx_ready;
        hold_data = rx_data;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  logic          found;
  int unsigned   svc, last_svc, polls, wr_seen, ptx, prx;
  logic [CW-1:0] s0, r0, ds, dr;

  initial begin
    reset = 1'b0; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    in_full = 1'b0; out_full = 1'b0; in_pkt = '0; in_pct = 0; drain_pct = 100;
    pend_pop = 1'b0; pend_wr = 1'b0; mon_en = 1'b0; hold_q = 1'b0;
    n_sent = 0; n_recv = 0;
    step(); step();
    mon_en = 1'b1;
    @(negedge clk);
    check_eq("rst_ctl", 64'(nic_ctl()), 64'(0));
    check_eq("rst_din", nic_d_in, 64'(0));
    check_eq("rst_rxv", 64'(rx_valid), 64'(0));
    check_eq("rst_rxd", rx_data, 64'(0));
    check_eq("rst_cnt", 64'({sent_cnt, recv_cnt}), 64'(0));
    check_eq("rst_txr", 64'(tx_ready), 64'(1));

    // --- single tx after reset: RX polled first (empty), then TX ---
    step(); reset = 1'b1; tx_valid = 1'b1; tx_data = 64'h8000_0000_0000_00A5;
    step(); tx_valid = 1'b0;
    @(negedge clk); check_eq("t1_pollrx", 64'(nic_ctl()), 64'(4'b1001));
    check_eq("t1_busy", 64'(tx_ready), 64'(0));
    step(); @(negedge clk); check_eq("t1_idle", 64'(nic_ctl()), 64'(4'b0000));
    step(); @(negedge clk); check_eq("t1_polltx", 64'(nic_ctl()), 64'(4'b1011));
    step(); @(negedge clk); check_eq("t1_write", 64'(nic_ctl()), 64'(4'b1110));
    check_eq("t1_din", nic_d_in, 64'h8000_0000_0000_00A5);
    step(); @(negedge clk); check_eq("t1_txr", 64'(tx_ready), 64'(1));
    check_eq("t1_sent", 64'(sent_cnt), 64'(1));

    // --- rx held while PE not ready ---
    step(); in_pkt = 64'h0000_0000_0000_1234; in_full = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      if (nic_ctl() == 4'b1001) found = 1'b1; else step();
    end
    check_eq("t2_poll", 64'(found), 64'(1));
    step(); @(negedge clk); check_eq("t2_read", 64'(nic_ctl()), 64'(4'b1000));
    step(); in_pkt = 64'h0000_0000_0000_5678; in_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("t2_rxv", 64'(rx_valid), 64'(1));
      check_eq("t2_rxd", rx_data, 64'h0000_0000_0000_1234);
      check_eq("t2_nopoll", 64'(nic_ctl()), 64'(0));
      step();
    end
    rx_ready = 1'b1;
    @(negedge clk); check_eq("t2_hs_idle", 64'(nic_ctl()), 64'(0));
    step(); rx_ready = 1'b0;
    @(negedge clk); check_eq("t2_idle", 64'(nic_ctl()), 64'(0));
    step(); @(negedge clk); check_eq("t2_repoll", 64'(nic_ctl()), 64'(4'b1001));
    step(); rx_ready = 1'b1;
    repeat (6) step();

    // --- both directions saturated: strict alternation ---
    s0 = CW'(n_sent); r0 = CW'(n_recv);
    tx_valid = 1'b1; in_pct = 100; drain_pct = 100;
    last_svc = 0; polls = 0;
    for (int i = 0; i < 90; i++) begin
      step(); tx_data = {$urandom, $urandom};
      @(negedge clk);
      svc = (nic_en && nic_addr == 2'b01) ? 1 : (nic_en && nic_addr == 2'b11) ? 2 : 0;
      if (svc != 0) begin
        if (last_svc != 0) check_eq("t3_alt", 64'(svc == last_svc), 64'(0));
        last_svc = svc;
        polls++;
      end
    end
    check_eq("t3_polls", 64'(polls >= 20), 64'(1));
    ds = sent_cnt - s0; dr = recv_cnt - r0;
    check_eq("t3_balance", 64'((ds > dr ? ds - dr : dr - ds) <= 1), 64'(1));

    // --- out-buffer stuck full: no writes, rx still served ---
    step(); tx_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (tx_ready) found = 1'b1; else step();
    end
    check_eq("t4_drained", 64'(found), 64'(1));
    step(); out_full = 1'b1; drain_pct = 0; tx_valid = 1'b1;
    wr_seen = 0; ptx = 0; prx = 0;
    for (int i = 0; i < 60; i++) begin
      step(); tx_data = {$urandom, $urandom};
      @(negedge clk);
      if (nic_wr_en) wr_seen++;
      if (nic_ctl() == 4'b1011) ptx++;
      if (nic_ctl() == 4'b1001) prx++;
    end
    check_eq("t4_no_wr", 64'(wr_seen), 64'(0));
    check_eq("t4_ptx", 64'(ptx >= 5), 64'(1));
    check_eq("t4_prx", 64'(prx >= 5), 64'(1));
    check_eq("t4_blocked", 64'(tx_ready), 64'(0));

    // --- reset during WRITE_TX ---
    step(); tx_valid = 1'b0; out_full = 1'b0; drain_pct = 100; in_pct = 0; rx_ready = 1'b1;
    repeat (12) step();
    tx_valid = 1'b1; tx_data = {$urandom, $urandom};
    step(); tx_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (nic_ctl() == 4'b1011) found = 1'b1; else step();
    end
    check_eq("t5_polltx", 64'(found), 64'(1));
    step(); reset = 1'b0;
    @(negedge clk); check_eq("t5_wr_cyc", 64'(nic_ctl()), 64'(4'b1110));
    step(); reset = 1'b1; tx_valid = 1'b1; tx_data = {$urandom, $urandom};
    in_full = 1'b1; in_pkt = {$urandom, $urandom};
    @(negedge clk);
    check_eq("t5_ctl", 64'(nic_ctl()), 64'(0));
    check_eq("t5_din", nic_d_in, 64'(0));
    check_eq("t5_txr", 64'(tx_ready), 64'(1));
    check_eq("t5_cnt", 64'({sent_cnt, recv_cnt}), 64'(0));
    check_eq("t5_no_write", 64'(out_full), 64'(0));
    step(); tx_valid = 1'b0;
    @(negedge clk); check_eq("t5_first_rx", 64'(nic_ctl()), 64'(4'b1001));
    step(); @(negedge clk); check_eq("t5_read", 64'(nic_ctl()), 64'(4'b1000));

    // --- randomized traffic ---
    in_pct = 40; drain_pct = 30;
    for (int i = 0; i < 3000; i++) begin
      step();
      tx_valid = 1'($urandom_range(1));
      tx_data  = {$urandom, $urandom};
      rx_ready = ($urandom_range(9) < 6);
    end

    // --- receive counter wrap ---
    tx_valid = 1'b0; rx_ready = 1'b1; in_pct = 100; drain_pct = 100;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      step();
      @(negedge clk);
      if (recv_cnt == '1) found = 1'b1;
    end
    check_eq("wrap_reach", 64'(found), 64'(1));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      @(negedge clk);
      if (recv_cnt != '1) found = 1'b1;
    end
    check_eq("recv_wrap", 64'(recv_cnt), 64'(0));

    in_pct = 0;
    repeat (10) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
